fsbm_search_ctrl: RTL and testbench

Row-sequencing controller for the full-search block-matching engine. It steps the 16 vertical search offsets in order. For each row it loads the reference row, runs the SAD array over the block, triggers the 16-candidate row comparator and collects that comparator's per-row minimum. It keeps the global minimum SAD and motion vector across all rows and reports it with a start/done handshake. It sits between the frame-level sequencer and the SAD array plus comparator datapath.

---
 rtl/fsbm_pkg.sv | 23 ++
 rtl/fsbm_search_ctrl_if.sv | 33 +++
 rtl/fsbm_best_tracker.sv | 36 +++
 rtl/fsbm_search_ctrl.sv | 153 +++++++++++++++
 tb/tb_fsbm_search_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fsbm_pkg.sv
// Shared types and constants for the full-search block-matching controller.
// Optional early termination is selected with FSBM_CTRL_EARLY_TERM_EN.
package fsbm_pkg;

  localparam int SAD_W    = 12;
  localparam int MV_W     = 8;
  localparam int MAX_ROWS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACC,
    DRAIN,
    CMP,
    WRES,
    FIN
  } fsbm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsbm_search_ctrl_if.sv
// Bundle between the search controller, the frame sequencer and the SAD/comparator datapath.
// Handshakes: start is a request sampled only while the controller idles;
// cmp_en is a one-cycle request and cmp_valid its response, honoured only while waiting for it.
interface fsbm_search_ctrl_if #(
  parameter int SAD_W = fsbm_pkg::SAD_W
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      ref_rd_en;
  logic [3:0]                ref_row;
  logic                      sad_clr;
  logic                      sad_en;
  logic                      cmp_en;
  logic [3:0]                ctrl_wd;
  logic                      cmp_valid;
  logic [SAD_W-1:0]          cmp_sad;
  logic [3:0]                cmp_mvx;
  logic [SAD_W-1:0]          best_sad;
  logic [fsbm_pkg::MV_W-1:0] best_mv;

  modport master (
    input  start, cmp_valid, cmp_sad, cmp_mvx,
    output busy, done, ref_rd_en, ref_row, sad_clr, sad_en, cmp_en, ctrl_wd,
           best_sad, best_mv
  );

  modport slave (
    output start, cmp_valid, cmp_sad, cmp_mvx,
    input  busy, done, ref_rd_en, ref_row, sad_clr, sad_en, cmp_en, ctrl_wd,
           best_sad, best_mv
  );
endinterface

// File: rtl/fsbm_best_tracker.sv
// Running-minimum register: keeps the smallest SAD seen and its motion vector.
// Strict less-than, so the earliest candidate wins a tie.
module fsbm_best_tracker #(
  parameter int SAD_W = fsbm_pkg::SAD_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_i,
  input  logic                      upd_valid_i,
  input  logic [SAD_W-1:0]          sad_i,
  input  logic [fsbm_pkg::MV_W-1:0] mv_i,
  output logic [SAD_W-1:0]          best_sad_o,
  output logic [fsbm_pkg::MV_W-1:0] best_mv_o
);
  import fsbm_pkg::*;

  logic [SAD_W-1:0] best_sad_q;
  logic [MV_W-1:0]  best_mv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad_q <= '0;
      best_mv_q  <= '0;
    end else if (init_i) begin
      best_sad_q <= '1;
      best_mv_q  <= '0;
    end else if (upd_valid_i && (sad_i < best_sad_q)) begin
      best_sad_q <= sad_i;
      best_mv_q  <= mv_i;
    end
  end

  assign best_sad_o = best_sad_q;
  assign best_mv_o  = best_mv_q;

endmodule

// File: rtl/fsbm_search_ctrl.sv
// Row sequencer for the full-search block matcher: LOAD/ACC/DRAIN/CMP/WRES per row, then FIN.
// Define FSBM_CTRL_EARLY_TERM_EN to end the search as soon as a row reports a zero SAD.
module fsbm_search_ctrl #(
  parameter int ROWS    = 16,
  parameter int BLK     = 16,
  parameter int SAD_LAT = 2,
  parameter int SAD_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fsbm_search_ctrl_if.master    bus,
  output fsbm_pkg::fsbm_state_e state_o
);
  import fsbm_pkg::*;

  localparam int              PH_MAX   = max_int(BLK, SAD_LAT);
  localparam int              PH_W     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] BLK_LAST = PH_W'(BLK - 1);
  localparam logic [PH_W-1:0] LAT_LAST = PH_W'((SAD_LAT > 0) ? SAD_LAT - 1 : 0);
  localparam logic [3:0]      ROW_LAST = 4'(ROWS - 1);

  fsbm_state_e     state_q;
  logic [3:0]      row_q;
  logic [PH_W-1:0] ph_q;
  logic            busy_q;
  logic            done_q;
  logic            ref_rd_en_q;
  logic            sad_clr_q;
  logic            sad_en_q;
  logic            cmp_en_q;

  logic            accept;
  logic            upd;
  logic            early_zero;
  logic            last_row;

  assign accept   = (state_q == IDLE) && bus.start;
  assign upd      = (state_q == WRES) && bus.cmp_valid;
  assign last_row = (row_q == ROW_LAST);

`ifdef FSBM_CTRL_EARLY_TERM_EN
  assign early_zero = (bus.cmp_sad == '0);
`else
  assign early_zero = 1'b0;
`endif

  // Strobes are registered for the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      ph_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ref_rd_en_q <= 1'b0;
      sad_clr_q   <= 1'b0;
      sad_en_q    <= 1'b0;
      cmp_en_q    <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      ref_rd_en_q <= 1'b0;
      sad_clr_q   <= 1'b0;
      cmp_en_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= LOAD;
            row_q       <= '0;
            busy_q      <= 1'b1;
            ref_rd_en_q <= 1'b1;
            sad_clr_q   <= 1'b1;
          end
        end
        LOAD: begin
          state_q  <= ACC;
          ph_q     <= '0;
          sad_en_q <= 1'b1;
        end
        ACC: begin
          if (ph_q == BLK_LAST) begin
            sad_en_q <= 1'b0;
            ph_q     <= '0;
            if (SAD_LAT == 0) begin
              state_q  <= CMP;
              cmp_en_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        DRAIN: begin
          if (ph_q == LAT_LAST) begin
            state_q  <= CMP;
            ph_q     <= '0;
            cmp_en_q <= 1'b1;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        CMP: begin
          state_q <= WRES;
        end
        WRES: begin
          if (bus.cmp_valid) begin
            if (last_row || early_zero) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q     <= LOAD;
              row_q       <= row_q + 4'd1;
              ref_rd_en_q <= 1'b1;
              sad_clr_q   <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fsbm_best_tracker #(
    .SAD_W(SAD_W)
  ) u_best (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_i      (accept),
    .upd_valid_i (upd),
    .sad_i       (bus.cmp_sad),
    .mv_i        ({bus.cmp_mvx, row_q}),
    .best_sad_o  (bus.best_sad),
    .best_mv_o   (bus.best_mv)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ref_rd_en = ref_rd_en_q;
  assign bus.ref_row   = row_q;
  assign bus.sad_clr   = sad_clr_q;
  assign bus.sad_en    = sad_en_q;
  assign bus.cmp_en    = cmp_en_q;
  assign bus.ctrl_wd   = row_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// Directed bench for fsbm_search_ctrl: a cycle-stepped comparator model answers cmp_en
// with hand-written per-row tables; results and timing are checked against fixed values.
module tb_fsbm_search_ctrl;
  import fsbm_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  fsbm_state_e state;

  fsbm_search_ctrl_if bus_if ();

  fsbm_search_ctrl #(
    .ROWS    (16),
    .BLK     (16),
    .SAD_LAT (2),
    .SAD_W   (12)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] sad_tab [16];
  logic [3:0]  mvx_tab [16];

  int          done_cyc, done_cnt, first_busy, first_ref, first_sad_en, first_cmp;
  int          busy_gaps, wd_err, sad_en_cnt;
  logic [11:0] sad_at1;
  bit          aborted;
  logic [63:0] abort_outs;
  fsbm_state_e abort_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus_if.busy, bus_if.done, bus_if.ref_rd_en, bus_if.ref_row, bus_if.sad_clr,
                bus_if.sad_en, bus_if.cmp_en, bus_if.ctrl_wd, bus_if.best_sad, bus_if.best_mv});
  endfunction

  // Cycle 0 is the cycle whose closing edge samples start; cmp_valid answers cmp_en
  // one cycle later, or seven cycles later on delay_row.
  task automatic run_search(input int delay_row, input int stray_row, input int abort_row,
                            input int restart_cyc);
    int pend;
    int r;
    bit stray_done;
    pend = 0; r = 0; stray_done = 0;
    done_cyc = -1; done_cnt = 0; first_busy = -1; first_ref = -1;
    first_sad_en = -1; first_cmp = -1; busy_gaps = 0; wd_err = 0; sad_en_cnt = 0;
    aborted = 0; sad_at1 = '0;
    @(negedge clk);
    bus_if.start = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      bus_if.start     = (cyc == restart_cyc);
      bus_if.cmp_valid = 1'b0;
      if (cyc == 1) sad_at1 = bus_if.best_sad;
      if (bus_if.busy && first_busy < 0) first_busy = cyc;
      if (bus_if.ref_rd_en && first_ref < 0) first_ref = cyc;
      if (bus_if.sad_en && first_sad_en < 0) first_sad_en = cyc;
      if (bus_if.cmp_en && first_cmp < 0) first_cmp = cyc;
      if (bus_if.sad_en) sad_en_cnt++;
      if (!bus_if.busy) busy_gaps++;
      if (bus_if.done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus_if.cmp_valid = 1'b1;
          bus_if.cmp_sad   = sad_tab[r];
          bus_if.cmp_mvx   = mvx_tab[r];
          r++;
        end
      end
      if (bus_if.cmp_en) begin
        if (bus_if.ctrl_wd !== 4'(r) || bus_if.ref_row !== 4'(r)) wd_err++;
        pend = (r == delay_row) ? 7 : 1;
      end
      if (r == stray_row && bus_if.sad_en && !stray_done) begin
        bus_if.cmp_valid = 1'b1;
        bus_if.cmp_sad   = '0;
        bus_if.cmp_mvx   = 4'hA;
        stray_done = 1;
      end
      if (r == abort_row && bus_if.sad_en) begin
        #2 rst_n = 1'b0;
        #1;
        aborted     = 1;
        abort_outs  = outs();
        abort_state = state;
        break;
      end
    end
    bus_if.start     = 1'b0;
    bus_if.cmp_valid = 1'b0;
  endtask

  task automatic fill_monotone();
    for (int i = 0; i < 16; i++) begin
      sad_tab[i] = 12'(100 + i);
      mvx_tab[i] = 4'(i);
    end
  endtask

  initial begin
    bus_if.start     = 1'b0;
    bus_if.cmp_valid = 1'b0;
    bus_if.cmp_sad   = '0;
    bus_if.cmp_mvx   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    chk("reset_state", 64'(state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", outs(), 64'd0);

    // Monotone SADs, with a stray start at cycle 100
    fill_monotone();
    run_search(-1, -1, -1, 100);
    chk("mono_done_cyc", 64'(done_cyc), 64'd337);
    chk("mono_done_cnt", 64'(done_cnt), 64'd1);
    chk("mono_first_busy", 64'(first_busy), 64'd1);
    chk("mono_first_ref", 64'(first_ref), 64'd1);
    chk("mono_first_sad_en", 64'(first_sad_en), 64'd2);
    chk("mono_first_cmp", 64'(first_cmp), 64'd20);
    chk("mono_init_best", 64'(sad_at1), 64'hFFF);
    chk("mono_sad_en_cnt", 64'(sad_en_cnt), 64'd256);
    chk("mono_busy_gaps", 64'(busy_gaps), 64'd0);
    chk("mono_ctrl_wd", 64'(wd_err), 64'd0);
    chk("mono_best_sad", 64'(bus_if.best_sad), 64'd100);
    chk("mono_best_mv", 64'(bus_if.best_mv), 64'h00);
    @(negedge clk);
    chk("mono_busy_after", 64'({bus_if.busy, bus_if.done}), 64'd0);
    chk("mono_state_after", 64'(state), 64'(IDLE));
    chk("mono_best_held", 64'({bus_if.best_sad, bus_if.best_mv}), 64'h06400);

    // Minimum on row 9, tie on row 12
    for (int i = 0; i < 16; i++) begin
      sad_tab[i] = 12'(50 + 3 * i);
      mvx_tab[i] = 4'(15 - i);
    end
    sad_tab[9]  = 12'd5;  mvx_tab[9]  = 4'd3;
    sad_tab[12] = 12'd5;  mvx_tab[12] = 4'd7;
    run_search(-1, -1, -1, -1);
    chk("min9_done_cyc", 64'(done_cyc), 64'd337);
    chk("min9_best_sad", 64'(bus_if.best_sad), 64'd5);
    chk("min9_best_mv", 64'(bus_if.best_mv), 64'h39);

    // Delayed response on row 4, stray cmp_valid during row 1 ACC
    for (int i = 0; i < 16; i++) begin
      sad_tab[i] = 12'(200 - 10 * i);
      mvx_tab[i] = 4'((i + 1) % 16);
    end
    run_search(4, 1, -1, -1);
    chk("delay_done_cyc", 64'(done_cyc), 64'd343);
    chk("delay_busy_gaps", 64'(busy_gaps), 64'd0);
    chk("delay_best_sad", 64'(bus_if.best_sad), 64'd50);
    chk("delay_best_mv", 64'(bus_if.best_mv), 64'h0F);

    // Zero SAD on row 2
    for (int i = 0; i < 16; i++) begin
      sad_tab[i] = 12'd40;
      mvx_tab[i] = 4'd1;
    end
    sad_tab[2] = 12'd0; mvx_tab[2] = 4'd6;
    run_search(-1, -1, -1, -1);
`ifdef FSBM_CTRL_EARLY_TERM_EN
    chk("zero_done_cyc", 64'(done_cyc), 64'd64);
    chk("zero_sad_en_cnt", 64'(sad_en_cnt), 64'd48);
`else
    chk("zero_done_cyc", 64'(done_cyc), 64'd337);
    chk("zero_sad_en_cnt", 64'(sad_en_cnt), 64'd256);
`endif
    chk("zero_best_sad", 64'(bus_if.best_sad), 64'd0);
    chk("zero_best_mv", 64'(bus_if.best_mv), 64'h62);

    // Asynchronous reset during row 5 ACC, then a clean restart
    fill_monotone();
    run_search(-1, -1, 5, -1);
    chk("abort_hit", 64'(aborted), 64'd1);
    chk("abort_outputs", abort_outs, 64'd0);
    chk("abort_state", 64'(abort_state), 64'(IDLE));
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_held", outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_search(-1, -1, -1, -1);
    chk("restart_done_cyc", 64'(done_cyc), 64'd337);
    chk("restart_best", 64'({bus_if.best_sad, bus_if.best_mv}), 64'h06400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
